// File: rtl/node_readout.sv
// node_readout - snapshot capture of N node outputs, serialized one node per beat on a valid/ready stream.
// Optional NODE_READOUT_DELTA_EN: emit the difference from the previous accepted snapshot.
module node_readout #(
  parameter int N_NODES = 3,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       snap,
  input  logic [N_NODES*WIDTH-1:0]   nodeval_bus,
  input  logic [N_NODES*WIDTH-1:0]   nodepos_bus,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [WIDTH-1:0]           out_val,
  output logic [WIDTH-1:0]           out_pos,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_overrun;
  logic             w_capture, w_ovr_evt, w_last;
  logic [WIDTH-1:0] r_shadow_val [N_NODES];
  logic [WIDTH-1:0] r_shadow_pos [N_NODES];
  logic [WIDTH-1:0] w_sel_val, w_sel_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A snap landing on the final beat transfer restarts the stream without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_ovr_evt   = 1'b0;
    w_last      = (r_state == S_SEND) && (r_idx == IDX_W'(N_NODES - 1));
    case (r_state)
      S_IDLE: begin
        if (snap) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (w_last) begin
            w_idx_nxt = '0;
            if (snap) w_capture = 1'b1;
            else      w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        if (snap && !(out_ready && w_last)) w_ovr_evt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_overrun <= 1'b0;
    else if (w_ovr_evt)   r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_shadow_val[i] <= '0;
        r_shadow_pos[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_shadow_val[i] <= nodeval_bus[i*WIDTH +: WIDTH];
        r_shadow_pos[i] <= nodepos_bus[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef NODE_READOUT_DELTA_EN
  logic [WIDTH-1:0] r_prev_val [N_NODES];
  logic [WIDTH-1:0] r_prev_pos [N_NODES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_prev_val[i] <= '0;
        r_prev_pos[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_prev_val[i] <= r_shadow_val[i];
        r_prev_pos[i] <= r_shadow_pos[i];
      end
    end
  end

  always_comb begin
    w_sel_val = '0;
    w_sel_pos = '0;
    for (int i = 0; i < N_NODES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_val = r_shadow_val[i] - r_prev_val[i];
        w_sel_pos = r_shadow_pos[i] - r_prev_pos[i];
      end
    end
  end
`else
  always_comb begin
    w_sel_val = '0;
    w_sel_pos = '0;
    for (int i = 0; i < N_NODES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_val = r_shadow_val[i];
        w_sel_pos = r_shadow_pos[i];
      end
    end
  end
`endif

  assign out_valid = (r_state == S_SEND);
  assign busy      = (r_state == S_SEND);
  assign out_index = r_idx;
  assign out_val   = w_sel_val;
  assign out_pos   = w_sel_pos;
  assign out_last  = w_last;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_node_readout.sv
// tb_node_readout - directed and random checks of node_readout against a snapshot-queue reference model.
module tb_node_readout;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            snap = 1'b0;
  logic [N*W-1:0]  nodeval_bus = '0;
  logic [N*W-1:0]  nodepos_bus = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IW-1:0]   out_index;
  logic [W-1:0]    out_val;
  logic [W-1:0]    out_pos;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic            clr_overrun = 1'b0;

  node_readout #(.N_NODES(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .snap(snap),
    .nodeval_bus(nodeval_bus), .nodepos_bus(nodepos_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_val(out_val), .out_pos(out_pos), .out_last(out_last),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [W-1:0]  v;
    logic [W-1:0]  p;
    logic          last;
  } beat_t;

  beat_t      q[$];
  logic [W-1:0] prev_v [N];
  logic [W-1:0] prev_p [N];
  logic       exp_ovr;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic [W-1:0] v0, v1, v2, p0, p1, p2);
    nodeval_bus = {v2, v1, v0};
    nodepos_bus = {p2, p1, p0};
  endtask

  task automatic model_clear();
    q.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin
      prev_v[i] = '0;
      prev_p[i] = '0;
    end
  endtask

  // One clock: apply inputs, advance the model, then check outputs 1 time unit after the edge.
  task automatic tick(input logic s, input logic rdy, input logic clr);
    logic consume, accept;
    beat_t b;
    logic [W-1:0] cv, cp;
    snap = s; out_ready = rdy; clr_overrun = clr;
    consume = (q.size() != 0) && rdy;
    accept  = s && ((q.size() == 0) || (q.size() == 1 && consume));
    if (consume) void'(q.pop_front());
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        cv = nodeval_bus[i*W +: W];
        cp = nodepos_bus[i*W +: W];
        b.idx = IW'(i);
`ifdef NODE_READOUT_DELTA_EN
        b.v = cv - prev_v[i];
        b.p = cp - prev_p[i];
`else
        b.v = cv;
        b.p = cp;
`endif
        prev_v[i] = cv;
        prev_p[i] = cp;
        b.last = (i == N - 1);
        q.push_back(b);
      end
    end
    if (s && !accept) exp_ovr = 1'b1;
    else if (clr)     exp_ovr = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
    chk("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
    if (q.size() != 0) begin
      chk("out_index", {62'd0, out_index}, {62'd0, q[0].idx});
      chk("out_val", {32'd0, out_val}, {32'd0, q[0].v});
      chk("out_pos", {32'd0, out_pos}, {32'd0, q[0].p});
      chk("out_last", {63'd0, out_last}, {63'd0, q[0].last});
    end else begin
      chk("idle_index", {62'd0, out_index}, 64'd0);
      chk("idle_last", {63'd0, out_last}, 64'd0);
    end
  endtask

  initial begin
    model_clear();
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_index", {62'd0, out_index}, 64'd0);
    chk("rst_val", {32'd0, out_val}, 64'd0);
    chk("rst_pos", {32'd0, out_pos}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic snapshot at full rate
    set_bus(10, 20, 30, 1, 2, 3);
    tick(1, 1, 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 0);

    // backpressure on beat 1
    tick(1, 1, 0);
    tick(0, 1, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 1, 0);

    // bus change right after capture must not leak into the snapshot
    tick(1, 1, 0);
    set_bus('1, '1, '1, 1, 2, 3);
    for (int k = 0; k < 4; k++) tick(0, 1, 0);
    set_bus(10, 20, 30, 1, 2, 3);

    // overrun during beat 0, then clear
    tick(1, 0, 0);
    tick(1, 0, 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);

    // set wins over clear
    tick(1, 0, 0);
    tick(1, 0, 1);
    tick(0, 1, 1);
    for (int k = 0; k < 3; k++) tick(0, 1, 0);

    // snap coincident with last-beat transfer
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    set_bus(11, 22, 33, 4, 5, 6);
    tick(1, 1, 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 0);

    // node0 10 then 4: delta build wraps to 0xFFFFFFFA
    set_bus(10, 20, 30, 1, 2, 3);
    tick(1, 1, 0);
    for (int k = 0; k < 3; k++) tick(0, 1, 0);
    set_bus(4, 20, 30, 1, 2, 3);
    tick(1, 1, 0);
    for (int k = 0; k < 3; k++) tick(0, 1, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        set_bus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
    end
    for (int k = 0; k < 6; k++) tick(0, 1, 0);

    // reset after beat 0 acts without a clock edge
    tick(1, 1, 0);
    tick(0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_index", {62'd0, out_index}, 64'd0);
    chk("arst_last", {63'd0, out_last}, 64'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    tick(0, 1, 0);
    tick(0, 1, 0);
    set_bus(7, 8, 9, 1, 2, 3);
    tick(1, 1, 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
